// File: rtl/tlb_unit.sv
// tlb_unit: fully associative joint TLB with a TLBP/TLBR/TLBWI sequencer and two lookup ports.
// Latency: accept -> EXEC -> RESP pulse two edges after accept, ready again one cycle later; lookups are combinational.
// Backpressure: cmd_ready is low while a command is in flight; the requester holds cmd_valid until accepted.
module tlb_unit #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic             cmd_done,

  input  logic [31:0]      c0_entryhi,
  input  logic [31:0]      c0_entrylo0,
  input  logic [31:0]      c0_entrylo1,
  input  logic [31:0]      c0_index,

  output logic             tlbp,
  output logic             tlbp_found,
  output logic [IDXW-1:0]  tlbp_index,

  output logic             tlbr,
  output logic [18:0]      r_vpn2,
  output logic [7:0]       r_asid,
  output logic             r_g,
  output logic [19:0]      r_pfn0,
  output logic [2:0]       r_c0,
  output logic             r_d0,
  output logic             r_v0,
  output logic [19:0]      r_pfn1,
  output logic [2:0]       r_c1,
  output logic             r_d1,
  output logic             r_v1,

  input  logic [31:0]      s0_vaddr,
  output logic [31:0]      s0_paddr,
  output logic             s0_miss,
  output logic             s0_invalid,
  output logic             s0_dirty,

  input  logic [31:0]      s1_vaddr,
  output logic [31:0]      s1_paddr,
  output logic             s1_miss,
  output logic             s1_invalid,
  output logic             s1_dirty
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_TLBP  = 2'b01;
  localparam logic [1:0] OP_TLBR  = 2'b10;
  localparam logic [1:0] OP_TLBWI = 2'b11;

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  logic [18:0] e_vpn2 [TLBNUM];
  logic [7:0]  e_asid [TLBNUM];
  logic        e_g    [TLBNUM];
  logic [19:0] e_pfn0 [TLBNUM];
  logic [2:0]  e_c0   [TLBNUM];
  logic        e_d0   [TLBNUM];
  logic        e_v0   [TLBNUM];
  logic [19:0] e_pfn1 [TLBNUM];
  logic [2:0]  e_c1   [TLBNUM];
  logic        e_d1   [TLBNUM];
  logic        e_v1   [TLBNUM];

  // ---------------------------------------------------------------------------
  // Sequencer state and command snapshot
  // ---------------------------------------------------------------------------
  state_t          state, state_d;
  logic            accept;
  logic [1:0]      op_q;

  logic [18:0]     sn_vpn2;
  logic [7:0]      sn_asid;
  logic            sn_g;
  logic [19:0]     sn_pfn0;
  logic [2:0]      sn_c0;
  logic            sn_d0;
  logic            sn_v0;
  logic [19:0]     sn_pfn1;
  logic [2:0]      sn_c1;
  logic            sn_d1;
  logic            sn_v1;
  logic [IDXW-1:0] sn_idx;

  // CP0 bits that carry no TLB meaning; kept out of the snapshot.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{c0_entryhi[12:8], c0_entrylo0[31:26], c0_entrylo1[31:26],
                             c0_index[31:IDXW]};

  // Next-state and command-handshake / pulse outputs.
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    tlbp      = 1'b0;
    tlbr      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        // op 00 is not a command; leave it sitting on the bus unaccepted
        if (cmd_valid && (cmd_op != 2'b00)) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        cmd_done = 1'b1;
        tlbp     = (op_q == OP_TLBP);
        tlbr     = (op_q == OP_TLBR);
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Snapshot op and CP0 fields at acceptance so later CP0 writes cannot leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= 2'b00;
      sn_vpn2 <= '0;
      sn_asid <= '0;
      sn_g    <= 1'b0;
      sn_pfn0 <= '0;
      sn_c0   <= '0;
      sn_d0   <= 1'b0;
      sn_v0   <= 1'b0;
      sn_pfn1 <= '0;
      sn_c1   <= '0;
      sn_d1   <= 1'b0;
      sn_v1   <= 1'b0;
      sn_idx  <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      sn_vpn2 <= c0_entryhi[31:13];
      sn_asid <= c0_entryhi[7:0];
      sn_g    <= c0_entrylo0[0] & c0_entrylo1[0];
      sn_pfn0 <= c0_entrylo0[25:6];
      sn_c0   <= c0_entrylo0[5:3];
      sn_d0   <= c0_entrylo0[2];
      sn_v0   <= c0_entrylo0[1];
      sn_pfn1 <= c0_entrylo1[25:6];
      sn_c1   <= c0_entrylo1[5:3];
      sn_d1   <= c0_entrylo1[2];
      sn_v1   <= c0_entrylo1[1];
      sn_idx  <= c0_index[IDXW-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Probe: compare every entry against the snapshot, lowest index wins
  // ---------------------------------------------------------------------------
  logic            probe_hit;
  logic [IDXW-1:0] probe_idx;

  // Priority search from the top down so the lowest matching index is left last.
  always_comb begin
    probe_hit = 1'b0;
    probe_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if ((e_vpn2[i] == sn_vpn2) && (e_g[i] || (e_asid[i] == sn_asid))) begin
        probe_hit = 1'b1;
        probe_idx = i[IDXW-1:0];
      end
    end
  end

  // Probe result registers; held until the next TLBP completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      tlbp_found <= 1'b0;
      tlbp_index <= '0;
    end else if ((state == S_EXEC) && (op_q == OP_TLBP)) begin
      tlbp_found <= probe_hit;
      tlbp_index <= probe_idx;
    end
  end

  // Read result registers; held until the next TLBR completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vpn2 <= '0;
      r_asid <= '0;
      r_g    <= 1'b0;
      r_pfn0 <= '0;
      r_c0   <= '0;
      r_d0   <= 1'b0;
      r_v0   <= 1'b0;
      r_pfn1 <= '0;
      r_c1   <= '0;
      r_d1   <= 1'b0;
      r_v1   <= 1'b0;
    end else if ((state == S_EXEC) && (op_q == OP_TLBR)) begin
      r_vpn2 <= e_vpn2[sn_idx];
      r_asid <= e_asid[sn_idx];
      r_g    <= e_g[sn_idx];
      r_pfn0 <= e_pfn0[sn_idx];
      r_c0   <= e_c0[sn_idx];
      r_d0   <= e_d0[sn_idx];
      r_v0   <= e_v0[sn_idx];
      r_pfn1 <= e_pfn1[sn_idx];
      r_c1   <= e_c1[sn_idx];
      r_d1   <= e_d1[sn_idx];
      r_v1   <= e_v1[sn_idx];
    end
  end

  // Entry array: cleared on reset, written by TLBWI on the EXEC->RESP edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        e_vpn2[i] <= '0;
        e_asid[i] <= '0;
        e_g[i]    <= 1'b0;
        e_pfn0[i] <= '0;
        e_c0[i]   <= '0;
        e_d0[i]   <= 1'b0;
        e_v0[i]   <= 1'b0;
        e_pfn1[i] <= '0;
        e_c1[i]   <= '0;
        e_d1[i]   <= 1'b0;
        e_v1[i]   <= 1'b0;
      end
    end else if ((state == S_EXEC) && (op_q == OP_TLBWI)) begin
      e_vpn2[sn_idx] <= sn_vpn2;
      e_asid[sn_idx] <= sn_asid;
      e_g[sn_idx]    <= sn_g;
      e_pfn0[sn_idx] <= sn_pfn0;
      e_c0[sn_idx]   <= sn_c0;
      e_d0[sn_idx]   <= sn_d0;
      e_v0[sn_idx]   <= sn_v0;
      e_pfn1[sn_idx] <= sn_pfn1;
      e_c1[sn_idx]   <= sn_c1;
      e_d1[sn_idx]   <= sn_d1;
      e_v1[sn_idx]   <= sn_v1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup ports (0 = fetch, 1 = data); match against the live EntryHi ASID
  // ---------------------------------------------------------------------------
  logic [31:0] lk_vaddr [2];
  assign lk_vaddr[0] = s0_vaddr;
  assign lk_vaddr[1] = s1_vaddr;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic            hit;
    logic [IDXW-1:0] idx;
    logic [19:0]     pfn;
    logic            pv;
    logic            pd;
    logic [31:0]     paddr;
    logic            miss;
    logic            invalid;
    logic            dirty;

    // Lowest-index match, then pick the even/odd page by va[12].
    always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if ((e_vpn2[i] == lk_vaddr[p][31:13]) &&
            (e_g[i] || (e_asid[i] == c0_entryhi[7:0]))) begin
          hit = 1'b1;
          idx = i[IDXW-1:0];
        end
      end
      pfn     = lk_vaddr[p][12] ? e_pfn1[idx] : e_pfn0[idx];
      pv      = lk_vaddr[p][12] ? e_v1[idx]   : e_v0[idx];
      pd      = lk_vaddr[p][12] ? e_d1[idx]   : e_d0[idx];
      miss    = !hit;
      invalid = hit && !pv;
      dirty   = hit && pd;
      paddr   = hit ? {pfn, lk_vaddr[p][11:0]} : 32'd0;
    end
  end

  assign s0_paddr   = g_port[0].paddr;
  assign s0_miss    = g_port[0].miss;
  assign s0_invalid = g_port[0].invalid;
  assign s0_dirty   = g_port[0].dirty;
  assign s1_paddr   = g_port[1].paddr;
  assign s1_miss    = g_port[1].miss;
  assign s1_invalid = g_port[1].invalid;
  assign s1_dirty   = g_port[1].dirty;

endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed stimulus with a response scoreboard for tlb_unit.
// Stimulus pushes the expected RESP (cycle and payload); a negedge monitor pops and compares.
// Lookup ports are checked directly after their inputs settle.
module tb_tlb_unit;

  localparam logic [1:0] OP_P  = 2'b01;
  localparam logic [1:0] OP_R  = 2'b10;
  localparam logic [1:0] OP_WI = 2'b11;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic        cmd_done;
  logic [31:0] c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index;
  logic        tlbp, tlbp_found;
  logic [3:0]  tlbp_index;
  logic        tlbr;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;
  logic [31:0] s0_vaddr, s1_vaddr, s0_paddr, s1_paddr;
  logic        s0_miss, s0_invalid, s0_dirty, s1_miss, s1_invalid, s1_dirty;

  tlb_unit #(.TLBNUM(16), .IDXW(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .c0_entryhi(c0_entryhi), .c0_entrylo0(c0_entrylo0), .c0_entrylo1(c0_entrylo1),
    .c0_index(c0_index),
    .tlbp(tlbp), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .tlbr(tlbr), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .s0_vaddr(s0_vaddr), .s0_paddr(s0_paddr), .s0_miss(s0_miss),
    .s0_invalid(s0_invalid), .s0_dirty(s0_dirty),
    .s1_vaddr(s1_vaddr), .s1_paddr(s1_paddr), .s1_miss(s1_miss),
    .s1_invalid(s1_invalid), .s1_dirty(s1_dirty)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;
    logic        found;
    logic [3:0]  idx;
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_probe(input logic found, input logic [3:0] idx);
    exp_t e;
    e = '0;
    e.kind = OP_P; e.found = found; e.idx = idx;
    return e;
  endfunction

  function automatic exp_t mk_write();
    exp_t e;
    e = '0;
    e.kind = OP_WI;
    return e;
  endfunction

  function automatic exp_t mk_read(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                   input logic [19:0] pfn0, input logic [2:0] c0,
                                   input logic d0, input logic v0,
                                   input logic [19:0] pfn1, input logic [2:0] c1,
                                   input logic d1, input logic v1);
    exp_t e;
    e = '0;
    e.kind = OP_R; e.vpn2 = vpn2; e.asid = asid; e.g = g;
    e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
    e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
    return e;
  endfunction

  // Present a command at a negedge, wait (bounded) for acceptance, optionally
  // queue its expected response two edges after the accepting edge.
  // cmd_valid is left asserted so callers can chain back-to-back commands.
  task automatic issue(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input logic [31:0] idx, input bit push,
                       input exp_t e, output int acc);
    int n;
    exp_t q;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op;
    c0_entryhi = hi; c0_entrylo0 = lo0; c0_entrylo1 = lo1; c0_index = idx;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = -1;
    if (!cmd_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout op=%0d cmd_ready=%0b required 1", op, cmd_ready);
    end else begin
      acc   = cyc + 1;
      q     = e;
      q.cyc = acc + 1;
      if (push) sb.push_back(q);
    end
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: every response pulse pops one expectation; pulses must be single-cycle.
  exp_t mon_e;
  bit   prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse = 1'b0;
    end else begin
      if (prev_pulse) check("pulse_width", {29'd0, cmd_done, tlbp, tlbr}, 32'd0);
      if (cmd_done || tlbp || tlbr) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_resp done=%0b tlbp=%0b tlbr=%0b required no pulse",
                   cmd_done, tlbp, tlbr);
        end else begin
          mon_e = sb.pop_front();
          check("resp_cycle", cyc, mon_e.cyc);
          check("cmd_done", cmd_done, 1);
          check("tlbp_pulse", tlbp, (mon_e.kind == OP_P));
          check("tlbr_pulse", tlbr, (mon_e.kind == OP_R));
          if (mon_e.kind == OP_P) begin
            check("tlbp_found", tlbp_found, mon_e.found);
            check("tlbp_index", tlbp_index, mon_e.idx);
          end
          if (mon_e.kind == OP_R) begin
            check("r_vpn2", r_vpn2, mon_e.vpn2);
            check("r_asid", r_asid, mon_e.asid);
            check("r_g", r_g, mon_e.g);
            check("r_pfn0", r_pfn0, mon_e.pfn0);
            check("r_pfn1", r_pfn1, mon_e.pfn1);
            check("r_cdv", {r_c0, r_d0, r_v0, r_c1, r_d1, r_v1},
                  {mon_e.c0, mon_e.d0, mon_e.v0, mon_e.c1, mon_e.d1, mon_e.v1});
          end
        end
      end
      prev_pulse = cmd_done || tlbp || tlbr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  a1, a2, ax;
    bit  seen;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    c0_entryhi = '0; c0_entrylo0 = '0; c0_entrylo1 = '0; c0_index = '0;
    s0_vaddr = '0; s1_vaddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_pulses", {cmd_done, tlbp, tlbr}, 0);
    check("rst_tlbp_found", tlbp_found, 0);
    check("rst_tlbp_index", tlbp_index, 0);
    check("rst_r_fields", {r_vpn2, r_asid, r_g}, 0);
    check("rst_r_pfns", {r_pfn0, r_pfn1}, 0);

    // all-zero entries: lookup of va 0 hits entry 0 but it is invalid
    s0_vaddr = 32'h0000_0000; c0_entryhi = 32'h0;
    #1;
    check("rst_s0_miss", s0_miss, 0);
    check("rst_s0_invalid", s0_invalid, 1);

    // an illegal op is never accepted
    cmd_valid = 1'b1; cmd_op = 2'b00;
    repeat (3) @(negedge clk);
    check("illegal_op_ready", cmd_ready, 1);
    cmd_valid = 1'b0;

    // probe after reset: every entry matches, lowest index 0
    issue(OP_P, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, mk_probe(1'b1, 4'd0), ax);
    drop_valid();
    drain();

    // TLBWI index 5, then TLBR index 5
    issue(OP_WI, 32'h0040_2003, 32'h0000_1017, 32'h0000_205F, 32'd5, 1'b1, mk_write(), ax);
    drop_valid();
    issue(OP_R, 32'h0, 32'h0, 32'h0, 32'd5, 1'b1,
          mk_read(19'h00201, 8'h03, 1'b1, 20'h00040, 3'd2, 1'b1, 1'b1,
                  20'h00081, 3'd3, 1'b1, 1'b1), ax);
    drop_valid();
    drain();

    // data-port translation on the odd page; global entry ignores ASID
    c0_entryhi = 32'h0040_2003; s1_vaddr = 32'h0040_3ABC; s0_vaddr = 32'h0040_2123;
    #1;
    check("s1_paddr", s1_paddr, 32'h0008_1ABC);
    check("s1_dirty", s1_dirty, 1);
    check("s1_miss", s1_miss, 0);
    check("s1_invalid", s1_invalid, 0);
    check("s0_paddr_even", s0_paddr, 32'h0004_0123);
    c0_entryhi = 32'h0000_0007;
    #1;
    check("s1_global_miss", s1_miss, 0);
    check("s1_global_paddr", s1_paddr, 32'h0008_1ABC);
    s1_vaddr = 32'h1234_0000;
    #1;
    check("s1_unmapped_miss", s1_miss, 1);
    check("s1_unmapped_paddr", s1_paddr, 32'h0);

    // probe miss
    issue(OP_P, 32'h1234_0000, 32'h0, 32'h0, 32'h0, 1'b1, mk_probe(1'b0, 4'd0), ax);
    drop_valid();
    drain();

    // write index 15 (upper index bits ignored), immediately probed
    issue(OP_WI, 32'h0080_0000, 32'h0000_3006, 32'h0000_4006, 32'hFFFF_FFEF, 1'b1,
          mk_write(), a1);
    issue(OP_P, 32'h0080_0000, 32'h0, 32'h0, 32'h0, 1'b1, mk_probe(1'b1, 4'd15), a2);
    check("wi_then_p_accept", a2, a1 + 3);
    drop_valid();
    drain();

    // held cmd_valid; index changes during EXEC must not affect the first write
    issue(OP_WI, 32'h0040_2003, 32'h0000_3006, 32'h0000_4006, 32'd9, 1'b1, mk_write(), a1);
    @(negedge clk);
    c0_index = 32'd10;
    issue(OP_WI, 32'h0040_2003, 32'h0000_3006, 32'h0000_4006, 32'd10, 1'b1, mk_write(), a2);
    check("b2b_accept", a2, a1 + 3);
    drop_valid();
    issue(OP_R, 32'h0, 32'h0, 32'h0, 32'd9, 1'b1,
          mk_read(19'h00201, 8'h03, 1'b0, 20'h000C0, 3'd0, 1'b1, 1'b1,
                  20'h00100, 3'd0, 1'b1, 1'b1), ax);
    drop_valid();
    // entries 5, 9, 10 all match: the lowest wins
    issue(OP_P, 32'h0040_2003, 32'h0, 32'h0, 32'h0, 1'b1, mk_probe(1'b1, 4'd5), ax);
    drop_valid();
    drain();
    c0_entryhi = 32'h0040_2003; s1_vaddr = 32'h0040_3ABC;
    #1;
    check("dup_lookup_paddr", s1_paddr, 32'h0008_1ABC);

    // reset while EXEC: no response, ready next cycle, entries cleared
    issue(OP_P, 32'h0040_2003, 32'h0, 32'h0, 32'h0, 1'b0, mk_probe(1'b1, 4'd5), ax);
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_exec_ready", cmd_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen = seen | tlbp;
      @(negedge clk);
    end
    check("rst_exec_no_tlbp", seen, 0);
    c0_entryhi = 32'h0040_2003; s1_vaddr = 32'h0040_3ABC;
    #1;
    check("rst_exec_cleared_miss", s1_miss, 1);
    check("rst_exec_cleared_paddr", s1_paddr, 32'h0);
    issue(OP_P, 32'h0040_2003, 32'h0, 32'h0, 32'h0, 1'b1, mk_probe(1'b0, 4'd0), ax);
    drop_valid();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/tlb_unit.md
# tlb_unit

16-entry fully associative joint TLB with a small command sequencer, paired with the CP0 register file. Executes TLBP, TLBR and TLBWI from the writeback stage using EntryHi, EntryLo0, EntryLo1 and Index driven by CP0. Returns probe and read results on CP0's `tlbp*` / `tlbr` / `r_*` inputs. Also provides two combinational translation ports, one for fetch and one for data.

## Interface
- `TLBNUM`, 16: number of entries.
- `IDXW`, 4: index width, log2(`TLBNUM`).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command request from WB.
- `cmd_op`  in  2  01 = TLBP, 10 = TLBR, 11 = TLBWI; 00 is illegal and is ignored.
- `cmd_ready`  out  1  sequencer idle; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_done`  out  1  one-cycle pulse when a command completes.
- `c0_entryhi`, `c0_entrylo0`, `c0_entrylo1`, `c0_index`  in  32 each  CP0 register values.
- `tlbp`  out  1  probe-result pulse.
- `tlbp_found`  out  1  probe hit.
- `tlbp_index`  out  `IDXW`  index of the hit entry.
- `tlbr`  out  1  read-result pulse.
- `r_vpn2` [19], `r_asid` [8], `r_g` [1], `r_pfn0` [20], `r_c0` [3], `r_d0`, `r_v0`, `r_pfn1` [20], `r_c1` [3], `r_d1`, `r_v1`  out  read-result entry fields.
- `s0_vaddr`, `s1_vaddr`  in  32  lookup addresses (s0 = fetch, s1 = data).
- `s0_paddr`, `s1_paddr`  out  32  translated addresses.
- `s0_miss`, `s0_invalid`, `s0_dirty`, `s1_miss`, `s1_invalid`, `s1_dirty`  out  1 each  lookup status.

## Operation
- **Entry contents:** vpn2[18:0], asid[7:0], g, and per page {pfn[19:0], c[2:0], d, v}.
- **Reset:** clears every field of every entry to 0.
- **Field extraction from CP0:**
  - EntryHi: vpn2 = [31:13], asid = [7:0].
  - EntryLo: pfn = [25:6], c = [5:3], d = [2], v = [1], G = [0].
  - Index: [IDXW-1:0]; all upper bits ignored.
- **FSM states:** IDLE → EXEC → RESP → IDLE.
  - `cmd_ready` = (state == IDLE).
  - Accepting in IDLE latches `cmd_op` and snapshots all four CP0 inputs. CP0 writes after acceptance do not affect the in-flight command.
  - An illegal op in IDLE is not accepted and the FSM stays in IDLE.
- **EXEC:**
  - TLBP: compare every entry against the snapshot. Match = vpn2 equal && (g || asid equal). Register found and the lowest matching index.
  - TLBR: register the fields of entry[index] into the `r_*` output registers. `r_g` = entry g.
  - TLBWI: write entry[index] on the EXEC→RESP edge. g = lo0.G & lo1.G.
- **RESP:**
  - `cmd_done` = 1.
  - TLBP: `tlbp` = 1, with `tlbp_found` / `tlbp_index` valid. `tlbp_index` = 0 on a miss.
  - TLBR: `tlbr` = 1, with `r_*` valid.
  - TLBWI: only `cmd_done`.
- **Output hold:** `r_*`, `tlbp_found` and `tlbp_index` hold their values until the next TLBR or TLBP respectively.
- **Lookup (combinational, per port):**
  - Match uses va[31:13] and the live `c0_entryhi` asid, not the snapshot.
  - Page = va[12]. The lowest-index match wins.
  - miss = no match.
  - invalid = !miss & !v.
  - dirty = d.
  - paddr = {pfn, va[11:0]} on a hit; paddr = 0 on a miss.
- **Unmapped segments:** not handled here; the caller bypasses.

## Timing
- **Reset values:** state IDLE; `cmd_ready` = 1; `cmd_done`, `tlbp`, `tlbr`, `tlbp_found` = 0; `tlbp_index` = 0; all `r_*` = 0.
- **Cycle timing:** accept at edge T. EXEC during T..T+1. RESP pulses are high during cycle T+2. `cmd_ready` is high again in cycle T+3.
- **Throughput:** one command per 3 cycles. `cmd_valid` while busy is held off by `cmd_ready` = 0, and the requester must keep it asserted.
- **Pulse width:** `tlbp` / `tlbr` / `cmd_done` are exactly one cycle, so CP0 samples each exactly once.
- **TLBWI visibility:** lookups see the new entry from the cycle after the write edge (RESP onward). A TLBP issued immediately after sees the new entry.
- **Reset mid-command:** the FSM returns to IDLE, no RESP pulses are emitted, and the entries are cleared.
- **Duplicate matches:** the priority encoder always picks the lowest index, for both probe and lookup.

## Test plan
- **Reset:** probe with entryhi = 0 → `tlbp_found` = 1, `tlbp_index` = 0 (all-zero entries match). Lookup s0 va = 0x00000000 → `s0_invalid` = 1, `s0_miss` = 0.
- **Write then read:** TLBWI index = 5, entryhi = 0x00402003, lo0 = 0x00001017, lo1 = 0x0000205F. Then TLBR index = 5 → `tlbr` pulses in cycle T+2 with `r_vpn2` = 0x00201, `r_asid` = 0x03, `r_pfn0` = 0x40, `r_pfn1` = 0x81, `r_g` = 1.
- **Translation:** after the write above, s1 va = 0x00403ABC → `s1_paddr` = 0x00081ABC, `s1_dirty` = 1, `s1_miss` = 0. Entryhi asid = 0x07 → still a hit (g = 1).
- **Probe miss:** TLBP with entryhi = 0x12340000 → `tlbp_found` = 0, and the `cmd_done` / `tlbp` pulses are each exactly 1 cycle.
- **Busy and snapshot:** hold `cmd_valid` through a TLBWI and change `c0_index` in cycle T+1 → the original index is written and the second command is accepted in cycle T+3.
- **Reset in EXEC:** no `tlbp` pulse follows, and `cmd_ready` = 1 on the next cycle.
